if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline: PC register, next-PC select and IF/ID register.
//  Consumes IFWrite/ID_Write/ID_Flush from the hazard unit and redirects from ID (J/JR) and EX (branch).
//  Latches interrupt requests and takes them at a clean fetch boundary.
//  Bit 31 of PC is the supervisor bit.
// PARAMETERS
//  RESET_VECTOR  32'h8000_0000  PC after reset
//  IRQ_VECTOR    32'h8000_0004  PC on interrupt entry
//  EXC_VECTOR    32'h8000_0008  PC on exception entry
// PORTS
//  clk           in   1   single clock, all state updates on rising edge
//  reset         in   1   synchronous, active-low reset
//  IFWrite       in   1   1 = PC may advance; 0 = hold PC
//  ID_Write      in   1   1 = IF/ID may load; 0 = hold IF/ID
//  ID_Flush      in   1   1 = load bubble into IF/ID
//  Exception     in   1   exception request (overrides stall)
//  IRQ           in   1   level interrupt request
//  BranchTaken   in   1   EX-stage branch resolved taken
//  BranchTarget  in   32  EX-stage branch target
//  J             in   1   ID-stage j/jal
//  JR            in   1   ID-stage jr/jalr
//  JumpIndex     in   26  instr[25:0] of ID-stage jump
//  JRTarget      in   32  rs value for jr/jalr
//  imem_addr     out  32  = PC (combinational)
//  imem_rdata    in   32  instruction at imem_addr (same-cycle read)
//  IF_ID_Instr   out  32  registered instruction
//  IF_ID_PC4     out  32  registered PC+4
//  IF_ID_Valid   out  1   0 = bubble
//  IRQ_Taken     out  1   one-cycle pulse on interrupt entry
//  IRQ_EPC       out  32  PC of instruction replaced by interrupt (valid with IRQ_Taken)
// BEHAVIOUR
//  Reset (reset==0 at edge): PC=RESET_VECTOR; IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0;
//   irq_pending=0; IRQ_Taken=0; IRQ_EPC=0. Reset mid-operation discards all pending state.
//  PC4 = {PC[31], PC[30:0]+31'd4}: low 31 bits wrap, supervisor bit never changes by increment.
//  Next-PC priority, highest first:
//   1 Exception             -> EXC_VECTOR (applied even if IFWrite=0)
//   2 BranchTaken           -> {PC[31], BranchTarget[30:0]}
//   3 JR                    -> {JRTarget[31] & PC[31], JRTarget[30:0]} (user mode cannot set bit 31)
//   4 J                     -> {IF_ID_PC4[31:28], JumpIndex, 2'b00}
//   5 irq_pending & ~PC[31] -> IRQ_VECTOR
//   6 otherwise             -> PC4
//  Levels 2-6 update PC only when IFWrite=1; else PC holds.
//  IRQ: irq_pending set on any edge with IRQ=1, cleared only on entry.
//   Entry (level 5 selected with IFWrite=1): PC<=IRQ_VECTOR, IRQ_EPC<=PC, IRQ_Taken=1 for
//   one cycle, IF/ID loads bubble. Deferred while any higher redirect or stall is active,
//   and while PC[31]=1.
//  IF/ID update: Exception or ID_Flush or IRQ entry -> bubble (Instr=0, PC4=0, Valid=0);
//   else ID_Write=1 -> {imem_rdata, PC4, 1}; else hold. Flush beats Write.
//  Latency: instruction at PC appears on IF_ID_* one cycle later; redirect target fetched
//   the cycle after the redirect edge.
// TESTING
//  Reset release, IFWrite=ID_Write=1 -> imem_addr 8000_0000,_0004,_0008; IF_ID_PC4 trails by one cycle.
//  IFWrite=ID_Write=0 for 2 cycles at PC=8000_0010 -> PC and IF/ID hold, then resume at 8000_0014.
//  BranchTaken=1, BranchTarget=0000_0100, J=1, PC=0000_0040 -> next PC 0000_0100 (branch wins).
//  User mode PC=0000_0200, JR with JRTarget=8000_0300 -> PC=0000_0300; same in supervisor -> 8000_0300.
//  IRQ pulse 1 cycle, PC=0000_0400, no redirect -> PC=8000_0004, IRQ_EPC=0000_0400, Valid=0, one IRQ_Taken.
//  IRQ high while IFWrite=0 and Exception=1 -> PC=8000_0008, IRQ deferred (pending held by PC[31]=1).

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, prioritised next-PC select, IF/ID pipeline register
// and interrupt latch that enters at a clean user-mode fetch boundary.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFWrite,
  input  logic        ID_Write,
  input  logic        ID_Flush,
  input  logic        Exception,
  input  logic        IRQ,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        J,
  input  logic        JR,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JRTarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic        IRQ_Taken,
  output logic [31:0] IRQ_EPC
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic        irq_pending;
  logic        irq_entry;
  logic        if_id_bubble;

  assign imem_addr = pc;

  // Supervisor bit is sticky across sequential increment; low 31 bits wrap.
  always_comb begin
    pc4 = {pc[31], pc[30:0] + 31'd4};
  end

  // Next-PC priority; exception bypasses the stall, everything else needs IFWrite.
  always_comb begin
    pc_next   = pc;
    irq_entry = 1'b0;
    if (Exception) begin
      pc_next = EXC_VECTOR;
    end else if (IFWrite) begin
      if (BranchTaken) begin
        pc_next = {pc[31], BranchTarget[30:0]};
      end else if (JR) begin
        pc_next = {JRTarget[31] & pc[31], JRTarget[30:0]};
      end else if (J) begin
        pc_next = {IF_ID_PC4[31:28], JumpIndex, 2'b00};
      end else if (irq_pending && !pc[31]) begin
        pc_next   = IRQ_VECTOR;
        irq_entry = 1'b1;
      end else begin
        pc_next = pc4;
      end
    end
  end

  assign if_id_bubble = Exception | ID_Flush | irq_entry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_VECTOR;
      IF_ID_Instr <= 32'd0;
      IF_ID_PC4   <= 32'd0;
      IF_ID_Valid <= 1'b0;
      irq_pending <= 1'b0;
      IRQ_Taken   <= 1'b0;
      IRQ_EPC     <= 32'd0;
    end else begin
      pc          <= pc_next;
      // A request arriving on the entry edge itself stays latched.
      irq_pending <= IRQ | (irq_pending & ~irq_entry);
      IRQ_Taken   <= irq_entry;
      if (irq_entry) begin
        IRQ_EPC <= pc;
      end
      if (if_id_bubble) begin
        IF_ID_Instr <= 32'd0;
        IF_ID_PC4   <= 32'd0;
        IF_ID_Valid <= 1'b0;
      end else if (ID_Write) begin
        IF_ID_Instr <= imem_rdata;
        IF_ID_PC4   <= pc4;
        IF_ID_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random stimulus, all outputs compared
// each cycle against a priority-list reference model of the fetch stage.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        IFWrite;
  logic        ID_Write;
  logic        ID_Flush;
  logic        Exception;
  logic        IRQ;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        J;
  logic        JR;
  logic [25:0] JumpIndex;
  logic [31:0] JRTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        IRQ_Taken;
  logic [31:0] IRQ_EPC;

  int tests;
  int failures;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_pend, m_taken;

  if_stage dut (
    .clk(clk), .reset(reset), .IFWrite(IFWrite), .ID_Write(ID_Write), .ID_Flush(ID_Flush),
    .Exception(Exception), .IRQ(IRQ), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .J(J), .JR(JR), .JumpIndex(JumpIndex), .JRTarget(JRTarget), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid), .IRQ_Taken(IRQ_Taken), .IRQ_EPC(IRQ_EPC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    reset = 1'b1; IFWrite = 1'b1; ID_Write = 1'b1; ID_Flush = 1'b0; Exception = 1'b0;
    IRQ = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'd0; J = 1'b0; JR = 1'b0;
    JumpIndex = 26'd0; JRTarget = 32'd0;
  endtask

  // One clock of the reference model, evaluated from pre-edge state and inputs.
  task automatic model_step();
    logic [31:0] seq, npc;
    logic        enter;
    if (!reset) begin
      m_pc = 32'h8000_0000; m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      m_pend = 1'b0; m_taken = 1'b0; m_epc = 32'd0;
    end else begin
      seq   = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7fff_ffff);
      enter = 1'b0;
      if (Exception)                   npc = 32'h8000_0008;
      else if (!IFWrite)               npc = m_pc;
      else if (BranchTaken)            npc = (m_pc & 32'h8000_0000) | (BranchTarget & 32'h7fff_ffff);
      else if (JR)                     npc = (JRTarget & m_pc & 32'h8000_0000) | (JRTarget & 32'h7fff_ffff);
      else if (J)                      npc = (m_pc4 & 32'hf000_0000) | (32'(JumpIndex) << 2);
      else if (m_pend && m_pc < 32'h8000_0000) begin
        npc = 32'h8000_0004; enter = 1'b1;
      end else                         npc = seq;
      if (Exception || ID_Flush || enter) begin
        m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (ID_Write) begin
        m_instr = mem(m_pc); m_pc4 = seq; m_valid = 1'b1;
      end
      if (enter) m_epc = m_pc;
      m_taken = enter;
      m_pend  = IRQ ? 1'b1 : (enter ? 1'b0 : m_pend);
      m_pc    = npc;
    end
  endtask

  task automatic check_all();
    check("imem_addr",   imem_addr,          m_pc);
    check("IF_ID_Instr", IF_ID_Instr,        m_instr);
    check("IF_ID_PC4",   IF_ID_PC4,          m_pc4);
    check("IF_ID_Valid", 32'(IF_ID_Valid),   32'(m_valid));
    check("IRQ_Taken",   32'(IRQ_Taken),     32'(m_taken));
    check("IRQ_EPC",     IRQ_EPC,            m_epc);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    clk = 1'b0; tests = 0; failures = 0;
    set_idle(); reset = 1'b0;
    cyc(); cyc();
    check("rst_pc", imem_addr, 32'h8000_0000);
    check("rst_valid", 32'(IF_ID_Valid), 32'd0);

    // sequential fetch after reset release
    set_idle();
    cyc(); check("seq_pc1", imem_addr, 32'h8000_0004);
    check("seq_pc4_trail", IF_ID_PC4, 32'h8000_0004);
    cyc(); check("seq_pc2", imem_addr, 32'h8000_0008);
    cyc(); cyc(); check("seq_pc4", imem_addr, 32'h8000_0010);

    // two-cycle stall then resume
    IFWrite = 1'b0; ID_Write = 1'b0;
    cyc(); cyc(); check("stall_hold", imem_addr, 32'h8000_0010);
    check("stall_ifid", IF_ID_PC4, 32'h8000_0010);
    set_idle();
    cyc(); check("stall_resume", imem_addr, 32'h8000_0014);

    // drop to user mode, then branch vs jump priority
    JR = 1'b1; JRTarget = 32'h0000_0040;
    cyc(); check("jr_user", imem_addr, 32'h0000_0040);
    set_idle(); BranchTaken = 1'b1; BranchTarget = 32'h0000_0100; J = 1'b1; JumpIndex = 26'h3ff_ffff;
    cyc(); check("br_over_j", imem_addr, 32'h0000_0100);

    // JR cannot raise the supervisor bit from user mode
    set_idle(); JR = 1'b1; JRTarget = 32'h0000_0200;
    cyc(); check("jr_200", imem_addr, 32'h0000_0200);
    JRTarget = 32'h8000_0300;
    cyc(); check("jr_user_clip", imem_addr, 32'h0000_0300);
    set_idle(); Exception = 1'b1;
    cyc(); check("exc_vec", imem_addr, 32'h8000_0008);
    set_idle(); JR = 1'b1; JRTarget = 32'h8000_0300;
    cyc(); check("jr_super", imem_addr, 32'h8000_0300);

    // one-cycle IRQ pulse latched while jumping to user code, entered next fetch
    JRTarget = 32'h0000_0400; IRQ = 1'b1;
    cyc(); check("irq_pre", imem_addr, 32'h0000_0400);
    set_idle();
    cyc(); check("irq_pc", imem_addr, 32'h8000_0004);
    check("irq_epc", IRQ_EPC, 32'h0000_0400);
    check("irq_bubble", 32'(IF_ID_Valid), 32'd0);
    check("irq_taken", 32'(IRQ_Taken), 32'd1);
    cyc(); check("irq_pulse_end", 32'(IRQ_Taken), 32'd0);

    // IRQ during stall plus exception: exception wins, IRQ stays pending in supervisor mode
    JR = 1'b1; JRTarget = 32'h0000_0500;
    cyc();
    set_idle(); IRQ = 1'b1; IFWrite = 1'b0; Exception = 1'b1;
    cyc(); check("exc_over_irq", imem_addr, 32'h8000_0008);
    check("irq_deferred", 32'(IRQ_Taken), 32'd0);
    set_idle();
    cyc(); cyc(); check("irq_super_hold", 32'(IRQ_Taken), 32'd0);
    JR = 1'b1; JRTarget = 32'h0000_0600;
    cyc(); check("irq_jr_first", imem_addr, 32'h0000_0600);
    set_idle();
    cyc(); check("irq_late_taken", 32'(IRQ_Taken), 32'd1);
    check("irq_late_epc", IRQ_EPC, 32'h0000_0600);

    // 31-bit wrap in user and supervisor modes
    JR = 1'b1; JRTarget = 32'h7fff_fffc;
    cyc(); set_idle();
    cyc(); check("wrap_user", imem_addr, 32'h0000_0000);
    Exception = 1'b1;
    cyc(); set_idle(); BranchTaken = 1'b1; BranchTarget = 32'h7fff_fffc;
    cyc(); check("br_keep_super", imem_addr, 32'hffff_fffc);
    set_idle();
    cyc(); check("wrap_super", imem_addr, 32'h8000_0000);

    // flush beats write
    ID_Flush = 1'b1;
    cyc(); check("flush_valid", 32'(IF_ID_Valid), 32'd0);
    set_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom % 64) != 0;
      IFWrite      = ($urandom % 4) != 0;
      ID_Write     = ($urandom % 4) != 0;
      ID_Flush     = ($urandom % 8) == 0;
      Exception    = ($urandom % 32) == 0;
      IRQ          = ($urandom % 12) == 0;
      BranchTaken  = ($urandom % 8) == 0;
      J            = ($urandom % 8) == 0;
      JR           = ($urandom % 6) == 0;
      BranchTarget = $urandom;
      JRTarget     = $urandom;
      JumpIndex    = 26'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
